// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch port: request/address out, ready/data back.
// The fetch unit uses the master side; the memory model uses the slave side.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the single-cycle RISC-V core: owns the PC, fetches one word per
// retirement, resolves next PC from branch/jump feedback and halts on system ops.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      rst,
  instr_fetch_unit_if.master        imem,
  output logic [31:0]               instruction,
  output logic                      instr_valid,
  output logic [31:0]               pc,
  output logic [31:0]               pc_plus4,
  input  logic                      retire,
  input  logic                      branch_taken,
  input  logic [31:0]               branch_target,
  input  logic                      pc_select,
  input  logic [31:0]               jump_target,
  output logic                      halted,
  output logic                      trap
);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        halted_q, halted_d;
  logic        trap_q, trap_d;
  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;

  // MISC-MEM (FENCE/PAUSE) and SYSTEM (ECALL/EBREAK) stop the core
  function automatic logic is_halt_opcode(input logic [4:0] op);
    return (op == 5'b00011) || (op == 5'b11100);
  endfunction

  assign pc_plus4_s = pc_q + 32'd4;

  // Next-PC selection: jump beats branch beats sequential
  always_comb begin
    target_s = pc_plus4_s;
    if (pc_select) begin
      target_s = {jump_target[31:1], 1'b0};
    end else if (branch_taken) begin
      target_s = branch_target;
    end else begin
      target_s = pc_plus4_s;
    end
  end

  // Fetch/hold/halt sequencing and architectural state updates
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    halted_d = halted_q;
    trap_d   = trap_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (retire) begin
          if (is_halt_opcode(instr_q[6:2])) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else if (target_s[1]) begin
            // pc stays on the faulting instruction for post-mortem
            state_d  = ST_HALT;
            halted_d = 1'b1;
            trap_d   = 1'b1;
          end else begin
            pc_d    = target_s;
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      halted_q <= 1'b0;
      trap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      halted_q <= halted_d;
      trap_q   <= trap_d;
    end
  end

  // Request is gated by reset so it drops immediately when reset asserts
  assign imem.imem_req  = rst & (state_q == ST_FETCH);
  assign imem.imem_addr = pc_q;
  assign instruction    = instr_q;
  assign instr_valid    = (state_q == ST_HOLD);
  assign pc             = pc_q;
  assign pc_plus4       = pc_plus4_s;
  assign halted         = halted_q;
  assign trap           = trap_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized memory latency, instruction mix and control-flow feedback.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [31:0] JAL    = 32'h0000_006F;
  localparam logic [31:0] BEQ    = 32'h0000_0063;
  localparam logic [31:0] JALR   = 32'h0000_8067;
  localparam logic [31:0] ECALL  = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, pc, pc_plus4, branch_target, jump_target;
  logic        instr_valid, retire, branch_taken, pc_select, halted, trap;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  logic [31:0] m_pc, m_instr;
  logic        m_hold, m_halted, m_trap;

  instr_fetch_unit_if imem_if ();

  instr_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem_if),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .retire        (retire),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_select     (pc_select),
    .jump_target   (jump_target),
    .halted        (halted),
    .trap          (trap)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic rbit();
    return 1'($urandom & 32'd1);
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9];
    logic [31:0] w;
    int          k;
    ops = '{7'h13, 7'h33, 7'h63, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h37, 7'h17};
    w = $urandom;
    k = $urandom_range(0, 19);
    if (k == 0)      w[6:0] = 7'h73;
    else if (k == 1) w[6:0] = 7'h0F;
    else             w[6:0] = ops[k % 9];
    return w;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_instr = NOP; m_hold = 1'b0; m_halted = 1'b0; m_trap = 1'b0;
  endtask

  task automatic check_outputs();
    logic req_e;
    req_e = !m_hold && !m_halted;
    check_val("imem_req", 32'(imem_if.imem_req), 32'(req_e));
    if (req_e) check_val("imem_addr", imem_if.imem_addr, m_pc);
    check_val("instr_valid", 32'(instr_valid), 32'(m_hold && !m_halted));
    check_val("pc", pc, m_pc);
    check_val("pc_plus4", pc_plus4, m_pc + 32'd4);
    check_val("instruction", instruction, m_instr);
    check_val("halted", 32'(halted), 32'(m_halted));
    check_val("trap", 32'(trap), 32'(m_trap));
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic cycle(input logic rdy, input logic [31:0] rd, input logic ret, input logic bt,
                       input logic [31:0] btg, input logic ps, input logic [31:0] jt);
    logic [31:0] tgt;
    imem_if.imem_ready = rdy;
    imem_if.imem_rdata = rd;
    retire = ret; branch_taken = bt; branch_target = btg; pc_select = ps; jump_target = jt;
    if (!m_halted) begin
      if (!m_hold) begin
        if (rdy) begin
          m_instr = rd;
          m_hold  = 1'b1;
        end
      end else if (ret) begin
        if (m_instr[6:2] == 5'b00011 || m_instr[6:2] == 5'b11100) begin
          m_halted = 1'b1;
        end else begin
          tgt = ps ? {jt[31:1], 1'b0} : (bt ? btg : m_pc + 32'd4);
          if (tgt[1]) begin
            m_halted = 1'b1;
            m_trap   = 1'b1;
          end else begin
            m_pc   = tgt;
            m_hold = 1'b0;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_random();
    cycle(rbit(), $urandom, rbit(), rbit(), rand_tgt(), rbit(), rand_tgt());
  endtask

  task automatic fetch(input logic [31:0] word, input int waits);
    for (int i = 0; i < waits; i++) cycle(1'b0, $urandom, rbit(), rbit(), rand_tgt(), rbit(), rand_tgt());
    cycle(1'b1, word, rbit(), rbit(), rand_tgt(), rbit(), rand_tgt());
  endtask

  task automatic retire_with(input logic bt, input logic [31:0] btg, input logic ps, input logic [31:0] jt);
    cycle(rbit(), $urandom, 1'b1, bt, btg, ps, jt);
  endtask

  // Asynchronous reset a little after the falling edge; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_val("rst_imem_req", 32'(imem_if.imem_req), 32'd0);
    check_val("rst_pc", pc, RST_PC);
    check_val("rst_instr", instruction, NOP);
    check_val("rst_valid", 32'(instr_valid), 32'd0);
    check_val("rst_halted", 32'(halted), 32'd0);
    check_val("rst_trap", 32'(trap), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs();
  endtask

  initial begin
    int waits_left;
    rst = 1'b1;
    imem_if.imem_ready = 1'b0; imem_if.imem_rdata = 32'd0;
    retire = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    pc_select = 1'b0; jump_target = 32'd0;
    model_reset();
    do_reset();

    // sequential ADDIs with zero-wait memory
    fetch(ADDI, 0);
    retire_with(1'b0, 32'd0, 1'b0, 32'd0);
    fetch(ADDI, 0);
    retire_with(1'b0, 32'd0, 1'b0, 32'd0);
    // jump to 0x10, branch taken with 3 wait states, then not taken
    fetch(JAL, 0);
    retire_with(1'b0, 32'd0, 1'b1, 32'h0000_0010);
    fetch(BEQ, 3);
    retire_with(1'b1, 32'h0000_0040, 1'b0, 32'd0);
    fetch(BEQ, 1);
    retire_with(1'b0, 32'h0000_0080, 1'b0, 32'd0);
    // JALR: jump beats branch and LSB cleared, then misaligned target traps
    fetch(JALR, 0);
    retire_with(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0101);
    fetch(JALR, 2);
    retire_with(1'b0, 32'd0, 1'b1, 32'h0000_0102);
    for (int i = 0; i < 20; i++) idle_random();

    // ECALL halts without trap
    do_reset();
    fetch(JAL, 0);
    retire_with(1'b0, 32'd0, 1'b1, 32'h0000_0020);
    fetch(ECALL, 1);
    retire_with(1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 20; i++) idle_random();

    // PC wrap and reset in the middle of a wait state
    do_reset();
    fetch(JAL, 0);
    retire_with(1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
    fetch(ADDI, 0);
    retire_with(1'b0, 32'd0, 1'b0, 32'd0);
    cycle(1'b0, $urandom, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cycle(1'b0, $urandom, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    imem_if.imem_ready = 1'b1;
    do_reset();

    // randomized traffic
    waits_left = $urandom_range(0, 3);
    for (int n = 0; n < 600; n++) begin
      if (m_halted) begin
        do_reset();
        waits_left = $urandom_range(0, 3);
      end else if (!m_hold) begin
        if (waits_left == 0) begin
          cycle(1'b1, rand_instr(), rbit(), rbit(), rand_tgt(), rbit(), rand_tgt());
          waits_left = $urandom_range(0, 3);
        end else begin
          waits_left--;
          cycle(1'b0, $urandom, rbit(), rbit(), rand_tgt(), rbit(), rand_tgt());
        end
      end else begin
        cycle(rbit(), $urandom, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
              rand_tgt(), 1'($urandom_range(0, 3) == 0), rand_tgt());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
